// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - unified instruction/data memory responder with PWM and timer window
// RV32I byte/half/word accesses onto block RAM plus LED PWM duty and micros/millis registers.
module data_mem_responder #(
  parameter int    MEM_WORDS   = 2048,
  parameter string INIT_FILE   = "",
  parameter int    CLK_FREQ_HZ = 12000000,
  parameter int    PWM_BITS    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        write_mem,
  input  logic [2:0]  funct3,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [29:0] WA_PWM    = 30'h3FFF_FFFF;
  localparam logic [29:0] WA_US     = 30'h3FFF_FFFE;
  localparam logic [29:0] WA_MS     = 30'h3FFF_FFFD;
  localparam int          PRE_DIV   = CLK_FREQ_HZ / 1000000;
  localparam int          PRE_W     = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

  // Size/alignment legality shared by loads and stores; illegal accesses read 0 and drop writes.
  function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: access_ok = 1'b1;
      3'b001, 3'b101: access_ok = ~a[0];
      3'b010:         access_ok = (a == 2'b00);
      default:        access_ok = 1'b0;
    endcase
  endfunction

  logic [31:0]         mem [MEM_WORDS];
  logic [PWM_BITS-1:0] duty_q [4];
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [3:0]          pwm_n_q;
  logic [PRE_W-1:0]    pre_q;
  logic [9:0]          sub_q;
  logic [31:0]         micros_q, millis_q;
  logic [31:0]         read_data_q, read_data_d;

  logic [3:0]          wr_be;
  logic [31:0]         wr_word;
  logic                wr_ram;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic [31:0]         rd_word, rd_shift, duty_word;
  logic                us_tick;

  assign wr_ram  = write_address < RAM_BYTES;
  assign wr_idx  = write_address[IDX_W+1:2];
  assign rd_idx  = read_address[IDX_W+1:2];
  assign wr_word = write_data << {write_address[1:0], 3'b000};
  assign us_tick = (pre_q == PRE_W'(PRE_DIV - 1));

  always_comb begin
    wr_be = 4'b0000;
    if (access_ok(funct3, write_address[1:0])) begin
      case (funct3[1:0])
        2'b00:   wr_be = 4'b0001 << write_address[1:0];
        2'b01:   wr_be = 4'b0011 << write_address[1:0];
        2'b10:   wr_be = 4'b1111;
        default: wr_be = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (write_mem && wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  always_comb begin
    duty_word = '0;
    for (int i = 0; i < 4; i++) duty_word[8*i +: 8] = 8'(duty_q[i]);
  end

  always_comb begin
    rd_word = '0;
    if (read_address < RAM_BYTES) begin
      rd_word = mem[rd_idx];
    end else begin
      case (read_address[31:2])
        WA_PWM:  rd_word = duty_word;
        WA_US:   rd_word = micros_q;
        WA_MS:   rd_word = millis_q;
        default: rd_word = '0;
      endcase
    end
  end

  assign rd_shift = rd_word >> {read_address[1:0], 3'b000};

  always_comb begin
    read_data_d = '0;
    if (access_ok(funct3, read_address[1:0])) begin
      case (funct3)
        3'b000:  read_data_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
        3'b100:  read_data_d = {24'h0, rd_shift[7:0]};
        3'b001:  read_data_d = {{16{rd_shift[15]}}, rd_shift[15:0]};
        3'b101:  read_data_d = {16'h0, rd_shift[15:0]};
        3'b010:  read_data_d = rd_shift;
        default: read_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) read_data_q <= '0;
    else        read_data_q <= read_data_d;
  end

  // Duty bytes update individually so a byte store touches only its own channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) duty_q[i] <= '0;
      pwm_cnt_q <= '0;
      pwm_n_q   <= 4'b1111;
    end else begin
      if (write_mem && write_address[31:2] == WA_PWM) begin
        for (int i = 0; i < 4; i++) begin
          if (wr_be[i]) duty_q[i] <= wr_word[8*i +: PWM_BITS];
        end
      end
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      for (int i = 0; i < 4; i++) pwm_n_q[i] <= ~(pwm_cnt_q < duty_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      sub_q    <= '0;
      micros_q <= '0;
      millis_q <= '0;
    end else if (us_tick) begin
      pre_q    <= '0;
      micros_q <= micros_q + 32'd1;
      if (sub_q == 10'd999) begin
        sub_q    <= '0;
        millis_q <= millis_q + 32'd1;
      end else begin
        sub_q <= sub_q + 10'd1;
      end
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign read_data = read_data_q;
  assign led       = pwm_n_q[0];
  assign red       = pwm_n_q[1];
  assign green     = pwm_n_q[2];
  assign blue      = pwm_n_q[3];

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
// Reads push expected results from a byte-level memory model; a monitor pops them one cycle later.
module tb_data_mem_responder;

  localparam int          MEM_WORDS = 256;
  localparam int          CLK_HZ    = 2000000;
  localparam int          US_DIV    = CLK_HZ / 1000000;
  localparam logic [31:0] RAM_BYTES = MEM_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_mem = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] write_address = '0, write_data = '0, read_address = '0;
  logic [31:0] read_data;
  logic        led, red, green, blue;

  data_mem_responder #(.MEM_WORDS(MEM_WORDS), .INIT_FILE(""), .CLK_FREQ_HZ(CLK_HZ), .PWM_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .write_mem(write_mem), .funct3(funct3),
    .write_address(write_address), .write_data(write_data), .read_address(read_address),
    .read_data(read_data), .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] v; string nm;} exp_t;
  exp_t        exp_q[$];
  bit   [7:0]  ram_m [int unsigned];
  bit   [7:0]  duty_m [4];
  int          cyc = 0;
  int          checks = 0, errors = 0;
  logic        rd_issue = 1'b0, mon_pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return a[0] == 1'b0;
      3'd2:       return a[1:0] == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    int unsigned us, ms;
    us = cyc / US_DIV;
    ms = cyc / (US_DIV * 1000);
    if (a < RAM_BYTES) return ram_m.exists(a) ? ram_m[a] : 8'h00;
    if (a >= 32'hFFFF_FFFC) return duty_m[a[1:0]];
    if (a >= 32'hFFFF_FFF8) return 8'(us >> (8 * a[1:0]));
    if (a >= 32'hFFFF_FFF4) return 8'(ms >> (8 * a[1:0]));
    return 8'h00;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v = '0;
    if (!legal(f3, a)) return '0;
    for (int i = 0; i < nbytes(f3); i++) v |= 32'(byte_at(a + 32'(i))) << (8 * i);
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic model_write(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ba;
    if (!legal(f3, a)) return;
    for (int i = 0; i < nbytes(f3); i++) begin
      ba = a + 32'(i);
      if (ba < RAM_BYTES) ram_m[ba] = d[8*i +: 8];
      else if (ba >= 32'hFFFF_FFFC) duty_m[ba[1:0]] = d[8*i +: 8];
    end
  endtask

  // One clock cycle of stimulus: drive at the falling edge, model is read before it is written.
  task automatic op(input bit we, input bit re, input logic [2:0] f3,
                    input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra);
    exp_t e;
    write_mem = we; funct3 = f3; write_address = wa; write_data = wd; read_address = ra;
    rd_issue = re;
    if (re) begin
      e.v = model_read(f3, ra);
      e.nm = $sformatf("rd f3=%0d a=%h", f3, ra);
      exp_q.push_back(e);
    end
    if (we) model_write(f3, wa, wd);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    write_mem = 1'b0;
    rd_issue = 1'b0;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mon_pend <= 1'b0;
    else        mon_pend <= rd_issue;
  end

  always @(negedge clk) begin
    if (mon_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: read_data %h with no expected entry", read_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk(e.nm, read_data, e.v);
      end
    end
  end

  initial begin
    int lo_led, lo_red, lo_green, lo_blue;
    logic [31:0] wa, ra;
    logic [2:0]  f3;
    bit          we, re;

    repeat (3) @(negedge clk);
    chk("reset read_data", read_data, 32'h0);
    chk("reset led", {31'h0, led}, 32'h1);
    chk("reset red", {31'h0, red}, 32'h1);
    chk("reset green", {31'h0, green}, 32'h1);
    chk("reset blue", {31'h0, blue}, 32'h1);
    rst_n = 1'b1;
    cyc = 0;

    for (int w = 0; w < 64; w++) op(1, 0, 3'd2, 32'(w * 4), $urandom, 32'h0);

    // Alignment and sign/zero extension
    op(1, 0, 3'd2, 32'h10, 32'h8000_00F1, 32'h0);
    op(0, 1, 3'd2, 0, 0, 32'h10);
    op(0, 1, 3'd0, 0, 0, 32'h10);
    op(0, 1, 3'd4, 0, 0, 32'h10);
    op(0, 1, 3'd1, 0, 0, 32'h10);
    op(0, 1, 3'd5, 0, 0, 32'h10);
    op(0, 1, 3'd1, 0, 0, 32'h12);
    op(0, 1, 3'd0, 0, 0, 32'h13);
    // Byte-lane merge
    op(1, 0, 3'd2, 32'h20, 32'h1122_3344, 0);
    op(1, 0, 3'd0, 32'h21, 32'h0000_00AA, 0);
    op(1, 0, 3'd1, 32'h22, 32'h0000_BEEF, 0);
    op(0, 1, 3'd2, 0, 0, 32'h20);
    // Misaligned, illegal, out of range
    op(1, 0, 3'd2, 32'h31, 32'hDEAD_BEEF, 0);
    op(0, 1, 3'd2, 0, 0, 32'h30);
    op(0, 1, 3'd1, 0, 0, 32'h33);
    op(0, 1, 3'd3, 0, 0, 32'h30);
    op(0, 1, 3'd2, 0, 0, 32'h0001_0000);
    op(0, 1, 3'd2, 0, 0, RAM_BYTES);
    // Read-first on the same word
    op(1, 0, 3'd2, 32'h40, 32'h9, 0);
    op(1, 1, 3'd2, 32'h40, 32'h5, 32'h40);
    op(0, 1, 3'd2, 0, 0, 32'h40);

    // PWM duty
    op(1, 0, 3'd0, 32'hFFFF_FFFD, 32'h40, 0);
    op(0, 1, 3'd2, 0, 0, 32'hFFFF_FFFC);
    idle(); idle();
    lo_led = 0; lo_red = 0; lo_green = 0; lo_blue = 0;
    for (int i = 0; i < 256; i++) begin
      if (led === 1'b0) lo_led++;
      if (red === 1'b0) lo_red++;
      if (green === 1'b0) lo_green++;
      if (blue === 1'b0) lo_blue++;
      idle();
    end
    chk("pwm red low count", 32'(lo_red), 32'd64);
    chk("pwm led low count", 32'(lo_led), 32'd0);
    chk("pwm green low count", 32'(lo_green), 32'd0);
    chk("pwm blue low count", 32'(lo_blue), 32'd0);
    op(1, 0, 3'd0, 32'hFFFF_FFFF, 32'hFF, 0);
    idle(); idle();
    lo_blue = 0; lo_red = 0;
    for (int i = 0; i < 256; i++) begin
      if (blue === 1'b0) lo_blue++;
      if (red === 1'b0) lo_red++;
      idle();
    end
    chk("pwm blue duty255 low count", 32'(lo_blue), 32'd255);
    chk("pwm red kept after byte store", 32'(lo_red), 32'd64);

    // Reset in the middle of an access
    op(0, 1, 3'd2, 0, 0, 32'h10);
    read_address = 32'h20; funct3 = 3'd2;
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    rd_issue = 1'b0;
    #1;
    chk("mid reset read_data", read_data, 32'h0);
    chk("mid reset red", {31'h0, red}, 32'h1);
    chk("mid reset blue", {31'h0, blue}, 32'h1);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("held reset read_data", read_data, 32'h0);
    for (int i = 0; i < 4; i++) duty_m[i] = 8'h00;
    rst_n = 1'b1;
    cyc = 0;

    // Timers
    while (cyc < 2000) idle();
    op(0, 1, 3'd2, 0, 0, 32'hFFFF_FFF8);
    op(0, 1, 3'd2, 0, 0, 32'hFFFF_FFF4);
    op(1, 1, 3'd2, 32'hFFFF_FFF8, 32'h1234_5678, 32'hFFFF_FFF8);
    op(1, 0, 3'd2, 32'hFFFF_FFF4, 32'hFFFF_FFFF, 0);
    op(0, 1, 3'd2, 0, 0, 32'hFFFF_FFF4);
    op(0, 1, 3'd2, 0, 0, 32'hFFFF_FFF8);
    op(0, 1, 3'd0, 0, 0, 32'hFFFF_FFF9);

    // Randomized mix
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        int cls;
        logic [31:0] a;
        cls = $urandom_range(0, 9);
        if (cls <= 5)      a = 32'($urandom_range(0, 255));
        else if (cls == 6) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        else if (cls == 7) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 3));
        else if (cls == 8) a = 32'hFFFF_FFF4 + 32'($urandom_range(0, 3));
        else               a = ($urandom_range(0, 1) != 0) ? RAM_BYTES + 32'($urandom_range(0, 7))
                                                           : 32'hFFFF_FFF0 + 32'($urandom_range(0, 3));
        if (k == 0) wa = a; else ra = a;
      end
      f3 = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 1) != 0) && (f3 != 3'd4) && (f3 != 3'd5);
      re = $urandom_range(0, 3) != 0;
      op(we, re, f3, wa, $urandom, ra);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle();
    if (exp_q.size() != 0) chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
